branch_resolve: RTL and testbench

Resolves control-flow instructions in the EX stage of the 16-bit five-stage pipeline, consuming the compare flag produced by the ALU under branch-decoder control. Decides taken/not-taken against a static predict-not-taken fetch policy, computes the target, issues a registered redirect to fetch with a valid/ready handshake, and squashes wrong-path instructions until fetch accepts. Also produces link-register writeback for JAL/JALR, a sticky halt, a sticky error, and saturating branch statistics.

---
 rtl/branch_resolve.sv | 136 +++++++++++++
 tb/tb_branch_resolve.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch/jump resolution with registered fetch redirect
// Predict-not-taken: taken control flow redirects fetch and flushes younger stages until accepted.
module branch_resolve #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic             ex_cond,
  input  logic [PC_W-1:0]  ex_pc_inc,
  input  logic [PC_W-1:0]  ex_imm,
  input  logic [PC_W-1:0]  ex_alu_out,
  input  logic             redir_ready,
  input  logic             stat_clr,
  output logic             redir_valid,
  output logic [PC_W-1:0]  redir_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             squash_ex,
  output logic             link_we,
  output logic [PC_W-1:0]  link_data,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {IDLE, REDIR} state_e;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic            is_cond, is_jump, is_reg_jump, is_link, known;
  logic            accepted, take, counted;
  logic [PC_W-1:0] target;

  always_comb begin
    is_cond     = (ex_opcode[4:2] == 3'b011);
    is_reg_jump = (ex_opcode == OP_JR) || (ex_opcode == OP_JALR);
    is_link     = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
    is_jump     = (ex_opcode == OP_J) || (ex_opcode == OP_JAL) || is_reg_jump;
    known       = is_cond || is_jump || (ex_opcode == OP_HALT) || (ex_opcode == OP_NOP);
    accepted    = ex_valid && (state_q == IDLE) && !halted_q;
    take        = accepted && (is_jump || (is_cond && ex_cond));
    counted     = accepted && (is_cond || is_jump);
    target      = is_reg_jump ? ex_alu_out : (ex_pc_inc + ex_imm);
  end

  always_comb begin
    state_d       = state_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    halted_d      = halted_q;
    err_d         = err_q;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d       = REDIR;
          redir_valid_d = 1'b1;
          redir_pc_d    = target;
        end
      end
      REDIR: begin
        if (redir_ready) begin
          state_d       = IDLE;
          redir_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accepted && (ex_opcode == OP_HALT)) halted_d = 1'b1;
    if (accepted && !known)                 err_d    = 1'b1;

    // Clear has priority over a same-cycle increment; increments saturate.
    if (stat_clr) begin
      br_cnt_d    = '0;
      taken_cnt_d = '0;
    end else begin
      if (counted && (br_cnt_q != '1))  br_cnt_d    = br_cnt_q + CNT_ONE;
      if (take && (taken_cnt_q != '1))  taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign flush_if    = !halted_q && (take || (state_q == REDIR));
  assign flush_id    = flush_if;
  assign squash_ex   = (state_q == REDIR) && ex_valid;
  assign link_we     = accepted && is_link;
  assign link_data   = ex_pc_inc;
  assign halted      = halted_q;
  assign err         = err_q;
  assign br_cnt      = br_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed plus random checks of branch_resolve against a reference model
module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        rst_n, ex_valid, ex_cond, redir_ready, stat_clr;
  logic [4:0]  ex_opcode;
  logic [15:0] ex_pc_inc, ex_imm, ex_alu_out;
  logic        redir_valid, flush_if, flush_id, squash_ex, link_we, halted, err;
  logic [15:0] redir_pc, link_data, br_cnt, taken_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_pend, m_halt, m_err;
  logic [15:0] m_tgt;
  int          m_br, m_tk;

  localparam logic [4:0] HALT = 5'd0, NOP = 5'd1, J = 5'd4, JR = 5'd5, JAL = 5'd6, JALR = 5'd7;
  localparam logic [4:0] BEQZ = 5'd12, BNEZ = 5'd13, BLTZ = 5'd14, BGEZ = 5'd15;

  branch_resolve dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_cond(ex_cond),
    .ex_pc_inc(ex_pc_inc), .ex_imm(ex_imm), .ex_alu_out(ex_alu_out), .redir_ready(redir_ready),
    .stat_clr(stat_clr), .redir_valid(redir_valid), .redir_pc(redir_pc), .flush_if(flush_if),
    .flush_id(flush_id), .squash_ex(squash_ex), .link_we(link_we), .link_data(link_data),
    .halted(halted), .err(err), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_branch(input logic [4:0] op);
    return op == BEQZ || op == BNEZ || op == BLTZ || op == BGEZ;
  endfunction

  function automatic bit is_jmp(input logic [4:0] op);
    return op == J || op == JAL || op == JR || op == JALR;
  endfunction

  // One clock: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit rst, input bit v, input logic [4:0] op, input bit cnd,
                      input logic [15:0] pci, input logic [15:0] imm, input logic [15:0] alu,
                      input bit rdy, input bit clr);
    bit acc, tk, known, cnt;
    logic [15:0] tgt;
    @(negedge clk);
    rst_n = rst; ex_valid = v; ex_opcode = op; ex_cond = cnd; ex_pc_inc = pci;
    ex_imm = imm; ex_alu_out = alu; redir_ready = rdy; stat_clr = clr;
    #1;
    known = is_branch(op) || is_jmp(op) || op == HALT || op == NOP;
    acc   = v && !m_pend && !m_halt;
    tk    = acc && (is_jmp(op) || (is_branch(op) && cnd));
    cnt   = acc && (is_branch(op) || is_jmp(op));
    tgt   = (op == JR || op == JALR) ? alu : 16'((32'(pci) + 32'(imm)) % 65536);
    chk("flush_if", flush_if, tk || m_pend);
    chk("flush_id", flush_id, tk || m_pend);
    chk("squash_ex", squash_ex, m_pend && v);
    chk("link_we", link_we, acc && (op == JAL || op == JALR));
    if (acc && (op == JAL || op == JALR)) chk("link_data", link_data, pci);
    if (!rst) begin
      m_pend = 0; m_tgt = 0; m_halt = 0; m_err = 0; m_br = 0; m_tk = 0;
    end else begin
      if (m_pend && rdy) m_pend = 0;
      if (tk) begin m_pend = 1; m_tgt = tgt; end
      if (acc && op == HALT) m_halt = 1;
      if (acc && !known) m_err = 1;
      if (clr) begin
        m_br = 0; m_tk = 0;
      end else begin
        m_br = (m_br + int'(cnt) > 65535) ? 65535 : m_br + int'(cnt);
        m_tk = (m_tk + int'(tk) > 65535) ? 65535 : m_tk + int'(tk);
      end
    end
    @(posedge clk);
    #1;
    chk("redir_valid", redir_valid, m_pend);
    if (m_pend || !rst) chk("redir_pc", redir_pc, m_tgt);
    chk("halted", halted, m_halt);
    chk("err", err, m_err);
    chk("br_cnt", br_cnt, 32'(m_br));
    chk("taken_cnt", taken_cnt, 32'(m_tk));
  endtask

  task automatic idle(input bit rdy);
    step(1, 0, NOP, 0, 16'h0, 16'h0, 16'h0, rdy, 0);
  endtask

  initial begin
    logic [4:0] ops [10] = '{HALT, NOP, BEQZ, BNEZ, BLTZ, BGEZ, J, JAL, JR, JALR};
    logic [4:0] rop;
    step(0, 0, NOP, 0, 0, 0, 0, 0, 0);
    step(0, 0, NOP, 0, 0, 0, 0, 0, 0);
    chk("reset_redir_valid", redir_valid, 0);
    chk("reset_br_cnt", br_cnt, 0);

    step(1, 1, BEQZ, 1, 16'h0010, 16'h0006, 16'h0, 1, 0);
    chk("beqz_pc", redir_pc, 16'h0016);
    idle(1);
    chk("beqz_valid_one_cycle", redir_valid, 0);
    chk("beqz_taken_cnt", taken_cnt, 1);

    repeat (3) step(1, 1, BNEZ, 0, 16'h0100, 16'h0020, 16'h0, 1, 0);
    chk("bnez_br_cnt", br_cnt, 4);

    step(1, 1, JALR, 0, 16'h0040, 16'h0, 16'h1234, 0, 0);
    repeat (3) step(1, 1, BEQZ, 1, 16'h0050, 16'h0002, 16'h0, 0, 0);
    step(1, 1, JAL, 0, 16'h0060, 16'h0002, 16'h0, 1, 0);
    chk("jalr_pc", redir_pc, 16'h1234);

    step(1, 1, J, 0, 16'hFFFE, 16'h0004, 16'h0, 1, 0);
    chk("wrap_pc", redir_pc, 16'h0002);
    idle(1);

    step(1, 1, 5'b11111, 1, 16'h0, 16'h0, 16'h0, 1, 0);
    idle(1);
    chk("err_sticky", err, 1);
    step(1, 1, HALT, 0, 16'h0, 16'h0, 16'h0, 1, 0);
    step(1, 1, BEQZ, 1, 16'h0010, 16'h0006, 16'h0, 1, 0);
    chk("halt_ignores_beqz", redir_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(1, 9)];
      if ($urandom_range(0, 199) == 0) rop = HALT;
      step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, rop, 1'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 79) == 0);
    end

    step(0, 0, NOP, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) step(1, 1, BNEZ, 0, 16'h0200, 16'h0004, 16'h0, 1, 0);
    chk("br_cnt_saturated", br_cnt, 16'hFFFF);
    step(1, 1, BGEZ, 0, 16'h0200, 16'h0004, 16'h0, 1, 1);
    chk("stat_clr_wins", br_cnt, 0);
    step(1, 1, J, 0, 16'h0300, 16'h0010, 16'h0, 0, 0);
    step(0, 0, NOP, 0, 0, 0, 0, 0, 0);
    chk("reset_mid_redir", redir_valid, 0);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
